cop_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one Alzette ISE co-processor datapath (the combinational `cop_*` ISE unit) between two independent requesters, e.g. two harts or a core plus a DMA-style test driver. It accepts requests with a valid/ready handshake and registers operands before issue. It captures the datapath result and write-enable into a result register and returns them on a per-requester response channel. It sits between the requesters' co-processor ports and the single ISE instance.

---
 rtl/cop_arbiter_if.sv | 39 +++
 rtl/cop_arbiter.sv | 107 ++++++++++
 tb/tb_cop_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop_arbiter_if.sv
// Bundle of requester, response and ISE-datapath signals for cop_arbiter.
// Every valid/ready pair transfers on a rising edge where both are high; payload is held while valid waits.
interface cop_arbiter_if #(parameter int XLEN = 64);
  logic            req0_valid, req0_ready;
  logic [31:0]     req0_insn;
  logic [XLEN-1:0] req0_rs1, req0_rs2;
  logic            req1_valid, req1_ready;
  logic [31:0]     req1_insn;
  logic [XLEN-1:0] req1_rs1, req1_rs2;

  logic            rsp0_valid, rsp0_wr, rsp0_ready;
  logic [XLEN-1:0] rsp0_rd;
  logic            rsp1_valid, rsp1_wr, rsp1_ready;
  logic [XLEN-1:0] rsp1_rd;

  logic            ise_valid, ise_rdywr, ise_wr, ise_ready;
  logic [31:0]     ise_insn;
  logic [XLEN-1:0] ise_rs1, ise_rs2, ise_rd;

  modport slave (
    input  req0_valid, req0_insn, req0_rs1, req0_rs2,
    input  req1_valid, req1_insn, req1_rs1, req1_rs2,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_wr, rsp0_rd, rsp1_valid, rsp1_wr, rsp1_rd,
    input  rsp0_ready, rsp1_ready,
    output ise_valid, ise_rdywr, ise_insn, ise_rs1, ise_rs2,
    input  ise_wr, ise_rd, ise_ready
  );

  modport master (
    output req0_valid, req0_insn, req0_rs1, req0_rs2,
    output req1_valid, req1_insn, req1_rs1, req1_rs2,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_wr, rsp0_rd, rsp1_valid, rsp1_wr, rsp1_rd,
    output rsp0_ready, rsp1_ready,
    input  ise_valid, ise_rdywr, ise_insn, ise_rs1, ise_rs2,
    output ise_wr, ise_rd, ise_ready
  );
endinterface

// File: rtl/cop_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of one Alzette ISE datapath.
// Optional COP_ARB_PERF_EN adds saturating grant and illegal-instruction counters.
module cop_arbiter #(
  parameter int XLEN = 64
) (
  input  logic         cop_clk,
  input  logic         cop_rst,
  cop_arbiter_if.slave bus,
  output logic [1:0]   fsm_state
`ifdef COP_ARB_PERF_EN
  ,
  output logic [31:0]  perf_issue0,
  output logic [31:0]  perf_issue1,
  output logic [31:0]  perf_illegal
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  logic            last, owner;
  logic [31:0]     op_insn;
  logic [XLEN-1:0] op_rs1, op_rs2;
  logic            res_wr;
  logic [XLEN-1:0] res_rd;

  logic            any_valid, gnt, owner_ready, can_grant, do_grant;
  logic [31:0]     gnt_insn;
  logic [XLEN-1:0] gnt_rs1, gnt_rs2;

  // A new grant is only possible once the previous owner's response is being consumed.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt = ~last;
    else                                  gnt = bus.req1_valid;
    owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;
    can_grant   = !cop_rst && ((state == IDLE) || ((state == RESP) && owner_ready));
    do_grant    = can_grant && any_valid;
    gnt_insn    = gnt ? bus.req1_insn : bus.req0_insn;
    gnt_rs1     = gnt ? bus.req1_rs1  : bus.req0_rs1;
    gnt_rs2     = gnt ? bus.req1_rs2  : bus.req0_rs2;
  end

  assign bus.req0_ready = do_grant & ~gnt;
  assign bus.req1_ready = do_grant &  gnt;

  assign bus.ise_valid = (state == EXEC);
  assign bus.ise_rdywr = (state == EXEC);
  assign bus.ise_insn  = op_insn;
  assign bus.ise_rs1   = op_rs1;
  assign bus.ise_rs2   = op_rs2;

  assign bus.rsp0_valid = (state == RESP) & ~owner;
  assign bus.rsp1_valid = (state == RESP) &  owner;
  assign bus.rsp0_wr    = bus.rsp0_valid & res_wr;
  assign bus.rsp1_wr    = bus.rsp1_valid & res_wr;
  assign bus.rsp0_rd    = bus.rsp0_valid ? res_rd : '0;
  assign bus.rsp1_rd    = bus.rsp1_valid ? res_rd : '0;

  assign fsm_state = state;

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      op_insn <= '0;
      op_rs1  <= '0;
      op_rs2  <= '0;
      res_wr  <= 1'b0;
      res_rd  <= '0;
    end else if (do_grant) begin
      state   <= EXEC;
      owner   <= gnt;
      last    <= gnt;
      op_insn <= gnt_insn;
      op_rs1  <= gnt_rs1;
      op_rs2  <= gnt_rs2;
    end else begin
      case (state)
        EXEC: if (bus.ise_ready) begin
          state  <= RESP;
          res_wr <= bus.ise_wr;
          res_rd <= bus.ise_wr ? bus.ise_rd : '0;
        end
        RESP: if (owner_ready) state <= IDLE;
        default: ;
      endcase
    end
  end

`ifdef COP_ARB_PERF_EN
  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      perf_issue0  <= '0;
      perf_issue1  <= '0;
      perf_illegal <= '0;
    end else begin
      if (bus.req0_ready && (perf_issue0 != 32'hFFFF_FFFF)) perf_issue0 <= perf_issue0 + 32'd1;
      if (bus.req1_ready && (perf_issue1 != 32'hFFFF_FFFF)) perf_issue1 <= perf_issue1 + 32'd1;
      if ((state == EXEC) && bus.ise_ready && !bus.ise_wr && (perf_illegal != 32'hFFFF_FFFF))
        perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cop_arbiter.sv
// Directed bench for cop_arbiter with a stub ISE datapath and a response scoreboard.
module tb_cop_arbiter;
  localparam int XLEN = 64;
  localparam int EW   = XLEN + 2;
  localparam int CW   = 256;

  logic       cop_clk = 1'b0;
  logic       cop_rst;
  logic [1:0] fsm_state;
`ifdef COP_ARB_PERF_EN
  logic [31:0] perf_issue0, perf_issue1, perf_illegal;
`endif
  logic       ise_stall;

  cop_arbiter_if #(.XLEN(XLEN)) bus ();

  cop_arbiter #(.XLEN(XLEN)) dut (
    .cop_clk   (cop_clk),
    .cop_rst   (cop_rst),
    .bus       (bus),
    .fsm_state (fsm_state)
`ifdef COP_ARB_PERF_EN
    ,
    .perf_issue0  (perf_issue0),
    .perf_issue1  (perf_issue1),
    .perf_illegal (perf_illegal)
`endif
  );

  // clock / watchdog
  always #5 cop_clk = ~cop_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stub datapath: custom opcode 0x0B rotates rs1 right by insn[30:25] and xors rs2;
  // anything else is unrecognised and drives a non-zero rd the arbiter must drop.
  function automatic logic [XLEN:0] ise_fn(input logic [31:0] insn, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    int sh;
    logic [XLEN-1:0] r;
    if (insn[6:0] == 7'h0B) begin
      sh = int'(insn[30:25]);
      r  = ((a >> sh) | (a << (XLEN - sh))) ^ b;
      return {1'b1, r};
    end
    return {1'b0, ~a};
  endfunction

  logic [XLEN:0] ise_out;
  assign ise_out       = ise_fn(bus.ise_insn, bus.ise_rs1, bus.ise_rs2);
  assign bus.ise_wr    = ise_out[XLEN];
  assign bus.ise_rd    = ise_out[XLEN-1:0];
  assign bus.ise_ready = ~ise_stall;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [EW-1:0] exp_entry(input logic who, input logic [31:0] insn,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN:0] o;
    o = ise_fn(insn, a, b);
    return {who, o[XLEN], (o[XLEN] ? o[XLEN-1:0] : {XLEN{1'b0}})};
  endfunction

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic          who;
    logic [EW-1:0] obs;
    if (bus.req0_ready) begin
      check("ready0_valid", CW'({bus.req0_valid, bus.req1_ready}), CW'(2'b10));
      exp_q.push_back(exp_entry(1'b0, bus.req0_insn, bus.req0_rs1, bus.req0_rs2));
    end
    if (bus.req1_ready) begin
      check("ready1_valid", CW'(bus.req1_valid), CW'(1'b1));
      exp_q.push_back(exp_entry(1'b1, bus.req1_insn, bus.req1_rs1, bus.req1_rs2));
    end
    check("rdywr", CW'(bus.ise_rdywr), CW'(bus.ise_valid));
    if ((bus.rsp0_valid && !bus.rsp0_ready) || (bus.rsp1_valid && !bus.rsp1_ready))
      check("ready_while_pending", CW'({bus.req0_ready, bus.req1_ready}), '0);
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      who = bus.rsp1_valid;
      obs = who ? {1'b1, bus.rsp1_wr, bus.rsp1_rd} : {1'b0, bus.rsp0_wr, bus.rsp0_rd};
      if (who) check("rsp_other_quiet", CW'({bus.rsp0_valid, bus.rsp0_wr, bus.rsp0_rd}), '0);
      else     check("rsp_other_quiet", CW'({bus.rsp1_valid, bus.rsp1_wr, bus.rsp1_rd}), '0);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", CW'(bus.rsp0_valid | bus.rsp1_valid), '0);
      end else begin
        check("rsp_data", CW'(obs), CW'(exp_q[0]));
        if (who ? bus.rsp1_ready : bus.rsp0_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("rsp_quiet", CW'({bus.rsp0_wr, bus.rsp0_rd, bus.rsp1_wr, bus.rsp1_rd}), '0);
    end
  endtask

  // driver tasks
  task automatic sample();
    @(negedge cop_clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge cop_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_insn = '0; bus.req0_rs1 = '0; bus.req0_rs2 = '0;
    bus.req1_valid = 1'b0; bus.req1_insn = '0; bus.req1_rs1 = '0; bus.req1_rs2 = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    ise_stall = 1'b0;
  endtask

  task automatic rand_req(input int idx);
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[6:0] = 7'h0B;
    if (idx == 0) begin
      bus.req0_insn = w; bus.req0_rs1 = {$urandom, $urandom}; bus.req0_rs2 = {$urandom, $urandom};
    end else begin
      bus.req1_insn = w; bus.req1_rs1 = {$urandom, $urandom}; bus.req1_rs2 = {$urandom, $urandom};
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ise"}, CW'({bus.ise_valid, bus.ise_rdywr, bus.ise_insn, bus.ise_rs1, bus.ise_rs2}), '0);
    check({tag, "_rsp"}, CW'({bus.rsp0_valid, bus.rsp0_wr, bus.rsp0_rd,
                              bus.rsp1_valid, bus.rsp1_wr, bus.rsp1_rd}), '0);
    check({tag, "_ready"}, CW'({bus.req0_ready, bus.req1_ready}), '0);
    check({tag, "_state"}, CW'(fsm_state), '0);
  endtask

  task automatic drain(input string tag);
    logic c0, c1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      sample();
      c0 = bus.req0_ready;
      c1 = bus.req1_ready;
      if (fsm_state == 2'd0 && exp_q.size() == 0 && !bus.req0_valid && !bus.req1_valid) break;
      advance();
      if (c0) bus.req0_valid = 1'b0;
      if (c1) bus.req1_valid = 1'b0;
    end
    check({tag, "_pending"}, CW'(exp_q.size()), '0);
    check({tag, "_idle"}, CW'(fsm_state), '0);
    advance();
  endtask

  initial begin
    logic            exp_g;
    logic            g0, g1;
    int              grants;
    logic [XLEN-1:0] keep_rs1;
    logic [31:0]     keep_insn;

    // reset
    idle_inputs();
    cop_rst = 1'b1;
    repeat (2) @(posedge cop_clk);
    #1;
    sample();
    check_zero("reset");
    advance();
    cop_rst = 1'b0;

    // single ROR on requester 0
    bus.req0_valid = 1'b1; bus.req0_insn = 32'h1000_000B;
    bus.req0_rs1 = 64'h0123_4567_89AB_CDEF; bus.req0_rs2 = '0;
    sample(); check("ror_accept", CW'(bus.req0_ready), CW'(1'b1)); advance();
    bus.req0_valid = 1'b0;
    sample();
    check("ror_issue", CW'({bus.ise_valid, bus.ise_insn, bus.ise_rs1}),
          CW'({1'b1, 32'h1000_000B, 64'h0123_4567_89AB_CDEF}));
    advance();
    sample();
    check("ror_rsp", CW'({bus.rsp0_valid, bus.rsp0_wr, bus.rsp0_rd}),
          CW'({1'b1, 1'b1, 64'hEF01_2345_6789_ABCD}));
    advance();
    drain("ror");

    // unrecognised instruction on requester 1
    bus.req1_valid = 1'b1; bus.req1_insn = 32'h0000_0033;
    bus.req1_rs1 = {$urandom, $urandom} | 64'h1; bus.req1_rs2 = {$urandom, $urandom};
    sample(); check("illegal_accept", CW'(bus.req1_ready), CW'(1'b1)); advance();
    bus.req1_valid = 1'b0;
    sample(); advance();
    sample();
    check("illegal_rsp", CW'({bus.rsp1_valid, bus.rsp1_wr, bus.rsp1_rd}), CW'({1'b1, 1'b0, 64'h0}));
`ifdef COP_ARB_PERF_EN
    check("perf_counts", CW'({perf_issue0, perf_issue1, perf_illegal}), CW'({32'd1, 32'd1, 32'd1}));
`endif
    advance();
    drain("illegal");

    // tie arbitration, both valid every cycle
    rand_req(0); rand_req(1);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    exp_g = 1'b0; grants = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      g0 = bus.req0_ready; g1 = bus.req1_ready;
      if (g0 || g1) begin
        check("tie_order", CW'({g0, g1}), CW'({~exp_g, exp_g}));
        exp_g = ~exp_g;
        grants++;
      end
      advance();
      if (g0) rand_req(0);
      if (g1) rand_req(1);
    end
    check("tie_grants", CW'(grants), CW'(6));
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain("tie");

    // response backpressure with requester 1 waiting
    bus.rsp0_ready = 1'b0;
    rand_req(0); bus.req0_valid = 1'b1;
    sample(); check("bp_accept", CW'(bus.req0_ready), CW'(1'b1)); advance();
    bus.req0_valid = 1'b0;
    rand_req(1); bus.req1_valid = 1'b1;
    sample(); check("bp_exec_ignore", CW'(bus.req1_ready), '0); advance();
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_hold", CW'({bus.rsp0_valid, bus.req1_ready, fsm_state}), CW'({1'b1, 1'b0, 2'd2}));
      advance();
    end
    bus.rsp0_ready = 1'b1;
    sample(); check("bp_release", CW'({bus.rsp0_valid, bus.req1_ready}), CW'(2'b11)); advance();
    bus.req1_valid = 1'b0;
    drain("bp");

    // stalled datapath
    ise_stall = 1'b1;
    rand_req(0); bus.req0_valid = 1'b1;
    keep_insn = bus.req0_insn; keep_rs1 = bus.req0_rs1;
    sample(); check("stall_accept", CW'(bus.req0_ready), CW'(1'b1)); advance();
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_hold", CW'({bus.ise_valid, bus.ise_insn, bus.ise_rs1, fsm_state}),
            CW'({1'b1, keep_insn, keep_rs1, 2'd1}));
      advance();
    end
    ise_stall = 1'b0;
    sample(); check("stall_capture", CW'({bus.ise_valid, bus.rsp0_valid}), CW'(2'b10)); advance();
    sample(); check("stall_rsp", CW'(bus.rsp0_valid), CW'(1'b1)); advance();
    drain("stall");

    // reset in flight, held together with a valid request
    rand_req(0); bus.req0_valid = 1'b1;
    sample(); check("rst_accept", CW'(bus.req0_ready), CW'(1'b1)); advance();
    bus.req0_valid = 1'b0;
    sample(); check("rst_exec", CW'(bus.ise_valid), CW'(1'b1));
    cop_rst = 1'b1;
    bus.req0_valid = 1'b1;
    exp_q.delete();
    advance();
    sample(); check_zero("rst_flight");
    advance();
    cop_rst = 1'b0;
    rand_req(0); rand_req(1);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    sample(); check("rst_first_tie", CW'({bus.req0_ready, bus.req1_ready}), CW'(2'b10)); advance();
    bus.req0_valid = 1'b0;
    drain("rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
